// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive path.
package rmii_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } rmii_state_e;

  localparam logic [1:0] DIBIT_PREAMBLE  = 2'b01;
  localparam logic [1:0] DIBIT_SFD_END   = 2'b11;
  localparam int         DIBITS_PER_BYTE = 4;
  localparam int         CNT_W           = $clog2(DIBITS_PER_BYTE);

endpackage

// File: rtl/rmii_byte_assembler.sv
// Collects dibits LSB-first into bytes and strobes each completed byte.
module rmii_byte_assembler
  import rmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       dibit_valid,
  input  logic [1:0] dibit,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIBITS_PER_BYTE - 1);

  logic [CNT_W-1:0] cnt;
  logic [7:0]       shift;

  // Shift new dibits in from the top so the earliest dibit ends up in bits [1:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shift      <= '0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (clear) begin
        cnt   <= '0;
        shift <= '0;
      end else if (dibit_valid) begin
        shift <= {dibit, shift[7:2]};
        cnt   <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          byte_data  <= {dibit, shift[7:2]};
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rmii_v1.sv
// RMII 100 Mb/s receiver: frame FSM plus byte assembly onto a strobe-only stream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | CRS_DV low; waiting for carrier
// PREAMBLE | carrier up, hunting for 01...11 (only when stripping)
// DATA     | every sampled dibit is payload
module rmii_v1
  import rmii_pkg::*;
#(
  parameter bit STRIP_PREAMBLE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] RXD,
  input  logic       CRS_DV,
  output logic [7:0] tx_tdata,
  output logic       tx_tvalid
);

  rmii_state_e state, state_next;
  logic        seen01, seen01_next;
  logic        dibit_valid;
  logic        asm_clear;

  // State and seen-01 flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      seen01 <= 1'b0;
    end else begin
      state  <= state_next;
      seen01 <= seen01_next;
    end
  end

  // Next-state logic; the dibit sampled on carrier rise already counts
  // toward the preamble hunt or is the first payload dibit.
  always_comb begin
    state_next  = state;
    seen01_next = seen01;
    dibit_valid = 1'b0;
    asm_clear   = 1'b0;
    if (!CRS_DV) begin
      state_next  = IDLE;
      seen01_next = 1'b0;
      asm_clear   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (STRIP_PREAMBLE) begin
            state_next  = PREAMBLE;
            seen01_next = (RXD == DIBIT_PREAMBLE);
          end else begin
            state_next  = DATA;
            dibit_valid = 1'b1;
          end
        end
        PREAMBLE: begin
          if (RXD == DIBIT_SFD_END && seen01) begin
            state_next  = DATA;
            seen01_next = 1'b0;
          end else if (RXD == DIBIT_PREAMBLE) begin
            seen01_next = 1'b1;
          end else if (RXD != DIBIT_SFD_END) begin
            seen01_next = 1'b0;
          end
        end
        DATA: begin
          dibit_valid = 1'b1;
        end
        default: begin
          state_next  = IDLE;
          seen01_next = 1'b0;
        end
      endcase
    end
  end

  rmii_byte_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (asm_clear),
    .dibit_valid (dibit_valid),
    .dibit       (RXD),
    .byte_data   (tx_tdata),
    .byte_valid  (tx_tvalid)
  );

endmodule

// File: tb/tb_rmii_v1.sv
// Bench for rmii_v1: one instance without and one with preamble stripping,
// driven by the same RMII stimulus and checked against expected byte lists.
module tb_rmii_v1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] RXD = 2'b00;
  logic       CRS_DV = 1'b0;
  logic [7:0] td0, td1;
  logic       tv0, tv1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int consec = 0;
  logic pv0 = 1'b0, pv1 = 1'b0;

  logic [7:0] cap0_d[$], cap1_d[$], exp0_d[$], exp1_d[$];
  int         cap0_c[$], cap1_c[$], exp0_c[$], exp1_c[$];
  logic [7:0] last0 = 8'h00, last1 = 8'h00;
  logic [1:0] frame[$];

  rmii_v1 #(.STRIP_PREAMBLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .RXD(RXD), .CRS_DV(CRS_DV), .tx_tdata(td0), .tx_tvalid(tv0)
  );
  rmii_v1 #(.STRIP_PREAMBLE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .RXD(RXD), .CRS_DV(CRS_DV), .tx_tdata(td1), .tx_tvalid(tv1)
  );

  always #10 clk = ~clk;

  // Cycle count and strobe capture, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (tv0) begin cap0_d.push_back(td0); cap0_c.push_back(cyc); end
    if (tv1) begin cap1_d.push_back(td1); cap1_c.push_back(cyc); end
    if ((tv0 && pv0) || (tv1 && pv1)) consec++;
    pv0 = tv0;
    pv1 = tv1;
  end

  task automatic clear_q();
    cap0_d.delete(); cap0_c.delete(); cap1_d.delete(); cap1_c.delete();
    exp0_d.delete(); exp0_c.delete(); exp1_d.delete(); exp1_c.delete();
  endtask

  task automatic push0(input logic [7:0] d, input int c);
    exp0_d.push_back(d); exp0_c.push_back(c); last0 = d;
  endtask

  task automatic push1(input logic [7:0] d, input int c);
    exp1_d.push_back(d); exp1_c.push_back(c); last1 = d;
  endtask

  // Drive the dibits in 'frame' on consecutive cycles, then drop carrier.
  task automatic drive_frame(output int start);
    start = cyc + 1;
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge clk); #1;
      if (i == 0) start = cyc;
      CRS_DV = 1'b1;
      RXD = frame[i];
    end
    @(negedge clk); #1;
    CRS_DV = 1'b0;
    RXD = 2'($urandom_range(0, 3));
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Reference: bytes are consecutive groups of four payload dibits; with
  // stripping, payload begins after the first 11 preceded by an unbroken run containing 01.
  task automatic model_frame(input int start);
    int p;
    bit seen;
    for (int i = 3; i < frame.size(); i += 4)
      push0({frame[i], frame[i-1], frame[i-2], frame[i-3]}, start + i + 1);
    p = -1;
    seen = 1'b0;
    for (int i = 0; i < frame.size(); i++) begin
      if (frame[i] == 2'b01) seen = 1'b1;
      else if (frame[i] == 2'b11) begin
        if (seen) begin p = i + 1; break; end
      end else seen = 1'b0;
    end
    if (p >= 0)
      for (int i = p + 3; i < frame.size(); i += 4)
        push1({frame[i], frame[i-1], frame[i-2], frame[i-3]}, start + i + 1);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    tests++;
    if (td0 !== 8'h00 || tv0 !== 1'b0 || td1 !== 8'h00 || tv1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: got %h/%b %h/%b expected 00/0", td0, tv0, td1, tv1);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (td0 !== 8'h00 || tv0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got %h/%b expected 00/0", td0, tv0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int s;
    clear_q();
    frame = '{2'd3, 2'd3, 2'd2, 2'd3};
    drive_frame(s);
    push0(8'hEF, s + 4);
    tests++;
    if (cap0_d.size() !== 1 || cap1_d.size() !== 0) begin
      fails++;
      $display("FAIL single_count: got %0d/%0d expected 1/0", cap0_d.size(), cap1_d.size());
    end else begin
      tests++;
      if (cap0_d[0] !== exp0_d[0] || cap0_c[0] !== exp0_c[0]) begin
        fails++;
        $display("FAIL single_byte: got %h@%0d expected %h@%0d", cap0_d[0], cap0_c[0], exp0_d[0], exp0_c[0]);
      end
    end
  endtask

  task automatic test_word();
    int s;
    logic [31:0] w;
    clear_q();
    w = 32'hDEADBEEF;
    frame.delete();
    for (int i = 0; i < 16; i++) frame.push_back(w[2*i +: 2]);
    drive_frame(s);
    push0(8'hEF, s + 4); push0(8'hBE, s + 8); push0(8'hAD, s + 12); push0(8'hDE, s + 16);
    tests++;
    if (cap0_d.size() !== 4) begin
      fails++;
      $display("FAIL word_count: got %0d expected 4", cap0_d.size());
    end
    for (int i = 0; i < 4 && i < cap0_d.size(); i++) begin
      tests++;
      if (cap0_d[i] !== exp0_d[i] || cap0_c[i] !== exp0_c[i]) begin
        fails++;
        $display("FAIL word_byte%0d: got %h@%0d expected %h@%0d", i, cap0_d[i], cap0_c[i], exp0_d[i], exp0_c[i]);
      end
    end
  endtask

  task automatic test_abort();
    int s;
    clear_q();
    frame = '{2'd2, 2'd1};
    drive_frame(s);
    frame = '{2'd0, 2'd0, 2'd0, 2'd1};
    drive_frame(s);
    push0(8'h40, s + 4);
    tests++;
    if (cap0_d.size() !== 1 || cap1_d.size() !== 0) begin
      fails++;
      $display("FAIL abort_count: got %0d/%0d expected 1/0", cap0_d.size(), cap1_d.size());
    end else begin
      tests++;
      if (cap0_d[0] !== exp0_d[0] || cap0_c[0] !== exp0_c[0]) begin
        fails++;
        $display("FAIL abort_byte: got %h@%0d expected %h@%0d", cap0_d[0], cap0_c[0], exp0_d[0], exp0_c[0]);
      end
    end
  endtask

  task automatic test_preamble();
    int s;
    clear_q();
    frame.delete();
    repeat (31) frame.push_back(2'b01);
    frame.push_back(2'b11);
    frame.push_back(2'b01); frame.push_back(2'b01); frame.push_back(2'b01); frame.push_back(2'b11);
    drive_frame(s);
    push1(8'hD5, s + 36);
    tests++;
    if (cap1_d.size() !== 1) begin
      fails++;
      $display("FAIL preamble_count: got %0d expected 1", cap1_d.size());
    end else begin
      tests++;
      if (cap1_d[0] !== exp1_d[0] || cap1_c[0] !== exp1_c[0]) begin
        fails++;
        $display("FAIL preamble_byte: got %h@%0d expected %h@%0d", cap1_d[0], cap1_c[0], exp1_d[0], exp1_c[0]);
      end
    end
    tests++;
    if (cap0_d.size() !== 9 || td0 !== 8'hD5) begin
      fails++;
      $display("FAIL preamble_raw: got %0d bytes last %h expected 9 bytes last d5", cap0_d.size(), td0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s;
    clear_q();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      CRS_DV = 1'b1;
      RXD = 2'(i + 1);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    last0 = 8'h00; last1 = 8'h00;
    #1;
    tests++;
    if (td0 !== 8'h00 || tv0 !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async: got %h/%b expected 00/0", td0, tv0);
    end
    @(posedge clk); #5;
    rst = 1'b0;
    frame = '{2'd2, 2'd3, 2'd0, 2'd1};
    drive_frame(s);
    push0(8'h4E, s + 4);
    tests++;
    if (cap0_d.size() !== 1 || cap1_d.size() !== 0) begin
      fails++;
      $display("FAIL midreset_count: got %0d/%0d expected 1/0", cap0_d.size(), cap1_d.size());
    end else begin
      tests++;
      if (cap0_d[0] !== exp0_d[0] || cap0_c[0] !== exp0_c[0]) begin
        fails++;
        $display("FAIL midreset_byte: got %h@%0d expected %h@%0d", cap0_d[0], cap0_c[0], exp0_d[0], exp0_c[0]);
      end
    end
  endtask

  task automatic test_random();
    int s;
    clear_q();
    consec = 0;
    for (int f = 0; f < 12; f++) begin
      frame.delete();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 9)) frame.push_back(2'b01);
        frame.push_back(2'b11);
      end
      repeat ($urandom_range(0, 24)) frame.push_back(2'($urandom_range(0, 3)));
      drive_frame(s);
      model_frame(s);
    end
    tests++;
    if (cap0_d.size() !== exp0_d.size() || cap1_d.size() !== exp1_d.size()) begin
      fails++;
      $display("FAIL random_count: got %0d/%0d expected %0d/%0d", cap0_d.size(), cap1_d.size(), exp0_d.size(), exp1_d.size());
    end
    for (int i = 0; i < exp0_d.size() && i < cap0_d.size(); i++) begin
      tests++;
      if (cap0_d[i] !== exp0_d[i] || cap0_c[i] !== exp0_c[i]) begin
        fails++;
        $display("FAIL random0_byte%0d: got %h@%0d expected %h@%0d", i, cap0_d[i], cap0_c[i], exp0_d[i], exp0_c[i]);
      end
    end
    for (int i = 0; i < exp1_d.size() && i < cap1_d.size(); i++) begin
      tests++;
      if (cap1_d[i] !== exp1_d[i] || cap1_c[i] !== exp1_c[i]) begin
        fails++;
        $display("FAIL random1_byte%0d: got %h@%0d expected %h@%0d", i, cap1_d[i], cap1_c[i], exp1_d[i], exp1_c[i]);
      end
    end
    tests++;
    if (td0 !== last0 || td1 !== last1) begin
      fails++;
      $display("FAIL random_hold: got %h/%h expected %h/%h", td0, td1, last0, last1);
    end
    tests++;
    if (consec !== 0) begin
      fails++;
      $display("FAIL random_consecutive_tvalid: got %0d expected 0", consec);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_word();
    test_abort();
    test_preamble();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
